// File: rtl/memory_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Data has priority; a starve counter forces a fetch grant after STARVE_LIMIT consecutive data wins.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wmask,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             if_elig, dm_elig, at_limit, fetch_win, data_win;

  // A requester whose completion pulse is high this cycle is still finishing its transaction.
  assign if_elig   = if_req & ~if_valid;
  assign dm_elig   = dm_req & ~dm_valid;
  assign at_limit  = (starve_cnt == LIMIT);
  assign fetch_win = (state == IDLE) & if_elig & (~dm_elig | at_limit);
  assign data_win  = (state == IDLE) & dm_elig & ~fetch_win;

  assign mem_req   = (state != IDLE);
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (fetch_win) begin
          state_nxt  = BUSY_I;
          starve_nxt = '0;
        end else if (data_win) begin
          state_nxt = BUSY_D;
          if (if_elig && !at_limit)
            starve_nxt = starve_cnt + 1'b1;
          else if (!if_req)
            starve_nxt = '0;
        end else if (!if_req) begin
          starve_nxt = '0;
        end
      end
      BUSY_D, BUSY_I: begin
        if (mem_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if_valid   <= (state == BUSY_I) & mem_ack;
      dm_valid   <= (state == BUSY_D) & mem_ack;
      if (state == BUSY_I && mem_ack)
        if_rdata <= mem_rdata;
      if (state == BUSY_D && mem_ack)
        dm_rdata <= mem_rdata;
      // Transaction fields are only loaded on a grant, so they hold for the whole busy window.
      if (fetch_win) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_wmask <= 4'h0;
      end else if (data_win) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_wmask <= dm_wmask;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_memory_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wmask;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem;

  always #5 clk = ~clk;

  memory_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the port, the captured transaction, pending completions.
  int          m_owner = 0;   // 0 none, 1 data, 2 fetch
  logic [31:0] m_addr = '0, m_wdata = '0, m_ifd = '0, m_dmd = '0;
  logic [3:0]  m_wmask = '0;
  logic        m_we = 1'b0, m_ifv = 1'b0, m_dmv = 1'b0;
  int          m_starve = 0;
  int          fetch_grants = 0, data_grants = 0;

  task automatic model_step();
    bit nif, ndm, if_ok, dm_ok;
    nif = 0;
    ndm = 0;
    if (rst) begin
      m_owner = 0; m_addr = '0; m_wdata = '0; m_wmask = '0; m_we = 0;
      m_ifd = '0; m_dmd = '0; m_ifv = 0; m_dmv = 0; m_starve = 0;
      return;
    end
    if (m_owner != 0) begin
      if (mem_ack) begin
        if (m_owner == 2) begin m_ifd = mem_rdata; nif = 1; end
        else begin m_dmd = mem_rdata; ndm = 1; end
        m_owner = 0;
      end
    end else begin
      if_ok = if_req && !m_ifv;
      dm_ok = dm_req && !m_dmv;
      if (if_ok && (!dm_ok || m_starve >= STARVE_LIMIT)) begin
        m_owner = 2; m_addr = if_addr; m_we = 0; m_wdata = '0; m_wmask = '0;
        m_starve = 0;
        fetch_grants++;
      end else if (dm_ok) begin
        m_owner = 1; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_wmask = dm_wmask;
        data_grants++;
        if (if_ok) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
        else if (!if_req) m_starve = 0;
      end else if (!if_req) begin
        m_starve = 0;
      end
    end
    m_ifv = nif;
    m_dmv = ndm;
  endtask

  task automatic check_outputs();
    check_eq("mem_req",   32'(mem_req),   32'(m_owner != 0));
    check_eq("mem_we",    32'(mem_we),    32'(m_we));
    check_eq("mem_addr",  mem_addr,       m_addr);
    check_eq("mem_wdata", mem_wdata,      m_wdata);
    check_eq("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
    check_eq("if_valid",  32'(if_valid),  32'(m_ifv));
    check_eq("dm_valid",  32'(dm_valid),  32'(m_dmv));
    check_eq("if_rdata",  if_rdata,       m_ifd);
    check_eq("dm_rdata",  dm_rdata,       m_dmd);
    check_eq("stall_if",  32'(stall_if),  32'(if_req && !m_ifv));
    check_eq("stall_mem", 32'(stall_mem), 32'(dm_req && !m_dmv));
  endtask

  // One clock: check settled outputs, advance DUT and model together.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0; dm_wmask = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    #1;
    check_eq("rst_mem_req",  32'(mem_req),  32'h0);
    check_eq("rst_mem_addr", mem_addr,      32'h0);
    check_eq("rst_if_valid", 32'(if_valid), 32'h0);
    check_eq("rst_dm_rdata", dm_rdata,      32'h0);
    tick();
    rst = 0;
    tick();

    // Single fetch, ack after three busy cycles
    if_req = 1; if_addr = 32'h10;
    tick();
    check_eq("f_mem_req",   32'(mem_req),   32'h1);
    check_eq("f_mem_addr",  mem_addr,       32'h10);
    check_eq("f_mem_we",    32'(mem_we),    32'h0);
    check_eq("f_mem_wmask", 32'(mem_wmask), 32'h0);
    tick();
    tick();
    mem_ack = 1; mem_rdata = 32'h13;
    tick();
    check_eq("f_if_valid", 32'(if_valid), 32'h1);
    check_eq("f_if_rdata", if_rdata,      32'h13);
    check_eq("f_stall_if", 32'(stall_if), 32'h0);
    mem_ack = 0; if_req = 0;
    tick();
    check_eq("f_if_valid_off", 32'(if_valid), 32'h0);
    check_eq("f_mem_req_off",  32'(mem_req),  32'h0);

    // Simultaneous requests: store first, fetch granted in the dm_valid cycle
    if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_wmask = 4'hF;
    tick();
    check_eq("s_mem_we",    32'(mem_we),    32'h1);
    check_eq("s_mem_addr",  mem_addr,       32'h100);
    check_eq("s_mem_wdata", mem_wdata,      32'hDEADBEEF);
    check_eq("s_mem_wmask", 32'(mem_wmask), 32'hF);
    mem_ack = 1; mem_rdata = 32'h0;
    tick();
    check_eq("s_dm_valid", 32'(dm_valid), 32'h1);
    check_eq("s_stall_if", 32'(stall_if), 32'h1);
    dm_req = 0; mem_ack = 0;
    tick();
    check_eq("s_fetch_req",  32'(mem_req), 32'h1);
    check_eq("s_fetch_addr", mem_addr,     32'h20);
    check_eq("s_fetch_we",   32'(mem_we),  32'h0);
    mem_ack = 1; mem_rdata = 32'h55;
    tick();
    check_eq("s_if_valid", 32'(if_valid), 32'h1);
    check_eq("s_if_rdata", if_rdata,      32'h55);
    if_req = 0; mem_ack = 0;
    tick();

    // Spurious ack while idle
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    check_eq("sp_if_valid", 32'(if_valid), 32'h0);
    check_eq("sp_dm_valid", 32'(dm_valid), 32'h0);
    check_eq("sp_if_rdata", if_rdata,      32'h55);
    check_eq("sp_dm_rdata", dm_rdata,      32'h0);
    mem_ack = 0;

    // Reset in the middle of a data transaction, ack right after
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    tick();
    tick();
    rst = 1;
    tick();
    check_eq("r_mem_req",  32'(mem_req), 32'h0);
    check_eq("r_mem_addr", mem_addr,     32'h0);
    rst = 0; dm_req = 0; mem_ack = 1; mem_rdata = 32'h77;
    tick();
    check_eq("r_dm_valid", 32'(dm_valid), 32'h0);
    check_eq("r_dm_rdata", dm_rdata,      32'h0);
    check_eq("r_mem_req2", 32'(mem_req),  32'h0);
    mem_ack = 0;
    tick();

    // Transaction fields held while the ack is withheld and inputs churn
    dm_req = 1; dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'h1234_5678; dm_wmask = 4'h3;
    tick();
    for (int i = 0; i < 10; i++) begin
      dm_addr = $urandom; dm_wdata = $urandom; dm_wmask = 4'($urandom);
      dm_we = 1'($urandom); if_req = 1'($urandom); if_addr = $urandom;
      tick();
      check_eq("st_mem_addr",  mem_addr,       32'h300);
      check_eq("st_mem_wdata", mem_wdata,      32'h1234_5678);
      check_eq("st_mem_wmask", 32'(mem_wmask), 32'h3);
      check_eq("st_mem_we",    32'(mem_we),    32'h1);
    end
    dm_req = 0; if_req = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    tick();

    // Both requesters held with zero-wait memory
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    mem_ack = 1; mem_rdata = 32'hA5A5_0000;
    fetch_grants = 0;
    for (int i = 0; i < 24; i++) begin
      mem_rdata = mem_rdata + 1;
      tick();
    end
    check_eq("hold_fetch_progress", 32'(fetch_grants > 0), 32'h1);
    idle_inputs();
    tick();
    tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      if_req    = ($urandom_range(0, 9) < 6);
      if_addr   = $urandom;
      dm_req    = ($urandom_range(0, 9) < 6);
      dm_we     = 1'($urandom);
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      dm_wmask  = 4'($urandom);
      mem_ack   = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
